mt_thread_sched: RTL
====================

Name: mt_thread_sched

Overview:
- Barrel-processor thread scheduler. It sits directly upstream of the multithreaded PC block in the fetch stage.
- Each cycle it picks the thread ID whose PC is fetched. It tracks a per-thread run state: off, ready, blocked, or halted.
- Thread state changes come from software enables and from execute/memory events (stall, wake, halt).
- Its registered tid output drives the PC block's tid input directly.

Parameters:
- NUM_THREADS, 8, number of hardware threads. Must be a power of two, ≥2.
- BITS_THREADS, $clog2(NUM_THREADS), width of a thread ID.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- thread_en  in  NUM_THREADS  software enable per thread. Level-sensitive.
- stall_req  in  1  block thread stall_tid (for example, a long-latency load).
- stall_tid  in  BITS_THREADS  thread to block.
- wake_req  in  1  release thread wake_tid from blocked.
- wake_tid  in  BITS_THREADS  thread to wake.
- halt_req  in  1  thread halt_tid executed ecall/ebreak-halt.
- halt_tid  in  BITS_THREADS  thread to halt.
- tid  out  BITS_THREADS  registered thread ID for the PC block.
- tid_valid  out  1  tid is a real issue slot. 0 means bubble; downstream squashes it.
- ready_mask  out  NUM_THREADS  registered; bit i = thread i in READY.
- all_halted  out  1  registered; no thread is READY or BLOCKED.

Behaviour:
- Per-thread state is 2 bits: OFF=0, READY=1, BLOCKED=2, HALTED=3.
- Reset (rst=0 at a clock edge):
  - all threads go to OFF; tid=0; tid_valid=0; ready_mask=0; all_halted=1.
  - the rotation pointer last=NUM_THREADS-1, so thread 0 is first after enable.
- State transitions per thread i, evaluated each cycle. Priority is top to bottom:
  1. thread_en[i]=0 → OFF, from any state.
  2. halt_req && halt_tid==i → HALTED.
  3. stall_req && stall_tid==i && state==READY → BLOCKED.
  4. wake_req && wake_tid==i && state==BLOCKED → READY.
  5. state==OFF && thread_en[i]=1 → READY.
  6. HALTED remains until thread_en[i] goes low.
  - wake on a READY thread is ignored; stall on a BLOCKED/OFF/HALTED thread is ignored.
  - Same-cycle stall and wake to the same tid: stall wins. Different tids: both apply.
- Selection uses the state registered at the current edge, so events affect selection one cycle later.
  - Consequence: the slot already issued for a just-stalled thread goes out with tid_valid=1. The execute stage squashes it.
- Default selection (SCHED_SKIP_EN defined):
  - candidate = first READY thread, searching cyclically from last+1 (mod NUM_THREADS, wrap-around).
  - If found: tid<=candidate, tid_valid<=1, last<=candidate.
  - If none is found: tid_valid<=0 and tid and last hold.
- Latency: thread_en rise at edge N → thread READY after edge N → earliest issue at edge N+1.
- ready_mask and all_halted are registered copies of the state vector, updated every cycle.
- Reset asserted mid-operation clears everything on that edge. No pending event survives reset.

Optional Feature:
- Macro: SCHED_SKIP_EN.
- Defined: work-conserving round-robin that skips non-READY threads, as described above.
- Undefined: strict barrel rotation.
  - Every cycle last<=last+1 (wraps) and tid<=last+1.
  - tid_valid<=1 only if that thread is READY; otherwise the slot is a bubble.
  - This gives a fixed NUM_THREADS-cycle revisit period per thread, which the hazard-free barrel pipeline relies on.

Test Plan:
- Reset, then thread_en=8'hFF → first valid cycle tid=0, then 1,2,…,7,0 with tid_valid=1 every cycle (both modes).
- thread_en=8'b0000_0101, SCHED_SKIP_EN defined → tid sequence 0,2,0,2, all valid. Undefined → tids 0..7 with tid_valid=1 only at 0 and 2.
- All enabled; stall_req tid=3, then wake_req tid=3 four cycles later → thread 3 absent from selection from one cycle after the stall until one cycle after the wake; ready_mask[3]=0 in between.
- Same cycle stall_req and wake_req both tid=5 while 5 is READY → thread 5 BLOCKED. Halt_req tid=5 while blocked → HALTED; stays HALTED until thread_en[5] drops, then re-rise gives READY.
- halt all enabled threads → all_halted=1 and tid_valid=0 one cycle after the last halt.
- rst=0 asserted mid-run with threads blocked → next cycle tid=0, tid_valid=0, ready_mask=0. After release with thread_en high, issue resumes at thread 0.

Source files
------------

// File: rtl/mt_thread_sched.sv
// Barrel-processor thread scheduler: tracks per-thread run state and picks the tid fetched each cycle.
// Optional macro SCHED_SKIP_EN selects work-conserving round-robin; undefined gives strict barrel rotation.
module mt_thread_sched #(
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    stall_req,
  input  logic [BITS_THREADS-1:0] stall_tid,
  input  logic                    wake_req,
  input  logic [BITS_THREADS-1:0] wake_tid,
  input  logic                    halt_req,
  input  logic [BITS_THREADS-1:0] halt_tid,
  output logic [BITS_THREADS-1:0] tid,
  output logic                    tid_valid,
  output logic [NUM_THREADS-1:0]  ready_mask,
  output logic                    all_halted
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_READY   = 2'd1,
    ST_BLOCKED = 2'd2,
    ST_HALTED  = 2'd3
  } thr_state_e;

  thr_state_e                state_r     [NUM_THREADS];
  thr_state_e                state_nxt_s [NUM_THREADS];
  logic [NUM_THREADS-1:0]    ready_s;
  logic [NUM_THREADS-1:0]    active_s;
  logic [BITS_THREADS-1:0]   last_r;
  logic [BITS_THREADS-1:0]   cand_s;
  logic [BITS_THREADS-1:0]   idx_s;
  logic                      cand_ok_s;

  // Per-thread next state; the if-chain order encodes event priority (stall beats wake).
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_nxt_s[i] = state_r[i];
      if (!thread_en[i]) begin
        state_nxt_s[i] = ST_OFF;
      end else if (halt_req && (halt_tid == BITS_THREADS'(i))) begin
        state_nxt_s[i] = ST_HALTED;
      end else if (stall_req && (stall_tid == BITS_THREADS'(i)) && (state_r[i] == ST_READY)) begin
        state_nxt_s[i] = ST_BLOCKED;
      end else if (wake_req && (wake_tid == BITS_THREADS'(i)) && (state_r[i] == ST_BLOCKED)) begin
        state_nxt_s[i] = ST_READY;
      end else if (state_r[i] == ST_OFF) begin
        state_nxt_s[i] = ST_READY;
      end else begin
        state_nxt_s[i] = state_r[i];
      end
    end
  end

  // Status vectors decoded from the registered state.
  always_comb begin
    ready_s  = {NUM_THREADS{1'b0}};
    active_s = {NUM_THREADS{1'b0}};
    for (int i = 0; i < NUM_THREADS; i++) begin
      ready_s[i]  = (state_r[i] == ST_READY);
      active_s[i] = (state_r[i] == ST_READY) || (state_r[i] == ST_BLOCKED);
    end
  end

`ifdef SCHED_SKIP_EN
  // Work-conserving pick: first READY thread after last, wrapping; k=NUM_THREADS revisits last itself.
  always_comb begin
    cand_s    = last_r;
    cand_ok_s = 1'b0;
    idx_s     = last_r;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx_s = last_r + BITS_THREADS'(k);
      if (!cand_ok_s && ready_s[idx_s]) begin
        cand_s    = idx_s;
        cand_ok_s = 1'b1;
      end else begin
        cand_ok_s = cand_ok_s;
      end
    end
  end
`else
  // Strict barrel pick: always the next slot; a non-READY owner turns it into a bubble.
  always_comb begin
    idx_s     = last_r + BITS_THREADS'(1);
    cand_s    = idx_s;
    cand_ok_s = ready_s[idx_s];
  end
`endif

  // State, rotation pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_r[i] <= ST_OFF;
      end
      last_r     <= BITS_THREADS'(NUM_THREADS - 1);
      tid        <= {BITS_THREADS{1'b0}};
      tid_valid  <= 1'b0;
      ready_mask <= {NUM_THREADS{1'b0}};
      all_halted <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_r[i] <= state_nxt_s[i];
      end
      ready_mask <= ready_s;
      all_halted <= ~|active_s;
`ifdef SCHED_SKIP_EN
      if (cand_ok_s) begin
        tid       <= cand_s;
        tid_valid <= 1'b1;
        last_r    <= cand_s;
      end else begin
        tid_valid <= 1'b0;
      end
`else
      last_r    <= cand_s;
      tid       <= cand_s;
      tid_valid <= cand_ok_s;
`endif
    end
  end

endmodule
